// File: rtl/ws2812_pkg.sv
// ws2812_pkg: constants shared between the ws2812_dri LED driver and the
// ws2812_rx decoder, plus the receiver state encoding.
//
// Timing values are in 50 MHz clock cycles (20 ns).
//   T0H / T0L     : high / low time of a 0 bit
//   T1H / T1L     : high / low time of a 1 bit
//   RESET_CYCLES  : line-low time that ends a frame
//   THRESH        : high widths at or above this decode as 1
//   MIN_HIGH      : shorter highs are glitches
//   MAX_HIGH      : a high reaching this width is a stuck line
package ws2812_pkg;

    localparam int T0H          = 17;
    localparam int T1H          = 45;
    localparam int T0L          = 45;
    localparam int T1L          = 17;
    localparam int RESET_CYCLES = 14000;
    localparam int THRESH       = 31;
    localparam int MIN_HIGH     = 5;
    localparam int MAX_HIGH     = 75;

    localparam int PIX_W        = 24;
    localparam int CNT_W        = 14;
    localparam int BIT_CNT_W    = 5;
    localparam int PIX_CNT_W    = 9;
    localparam int FWD_CNT_W    = 6;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_t;

    // Classify a measured high width as a data bit.
    function automatic logic decode_bit(input logic [CNT_W-1:0] width);
        return (width >= CNT_W'(THRESH));
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-pixel bus from the WS2812 receiver.
//
//   pix_data   : last decoded GRB word (bit 23 was first on the wire)
//   pix_valid  : one-cycle strobe, pix_data/pix_idx valid
//   pix_idx    : index of pix_data within the frame
//   frame_done : one-cycle strobe at the reset gap
//   pix_count  : complete pixels in the frame, valid with frame_done
//   err        : one-cycle strobe on a timing/format error
//
// master = receiver side, slave = consumer side.
interface ws2812_rx_if;
    import ws2812_pkg::*;

    logic [PIX_W-1:0]     pix_data;
    logic                 pix_valid;
    logic [PIX_CNT_W-1:0] pix_idx;
    logic                 frame_done;
    logic [PIX_CNT_W-1:0] pix_count;
    logic                 err;

    modport master (
        output pix_data, pix_valid, pix_idx, frame_done, pix_count, err
    );

    modport slave (
        input pix_data, pix_valid, pix_idx, frame_done, pix_count, err
    );

endinterface

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: brings the asynchronous WS2812 line into clk_50m.
// Two synchronizer flops, then a third stage that provides the
// settled level together with registered rise/fall strobes, all three
// aligned and three cycles behind the pin.
//
// Ports:
//   clk_50m : 50 MHz clock
//   rst_n   : asynchronous active-low reset
//   din     : raw line input
//   level   : synchronized line level
//   rise    : one-cycle strobe, level just went high
//   fall    : one-cycle strobe, level just went low
module ws2812_rx_sync (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic stable;

    // rise/fall compare against the old level, so they fire in the same
    // cycle that level first shows the new value.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= din;
            stable <= meta;
            level  <= stable;
            rise   <= stable & ~level;
            fall   <= ~stable & level;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire stream into 24-bit GRB words.
// Each synchronized high pulse is measured in 50 MHz cycles and
// classified as 0/1; 24 bits form a pixel; a long low marks end of frame.
// Malformed pulses (glitches, stuck-high, partial pixel, overflow) pulse err.
//
// Ports:
//   clk_50m : 50 MHz clock
//   rst_n   : asynchronous active-low reset
//   din     : asynchronous WS2812 line input
//   pix     : decoded pixel bus (ws2812_rx_if.master)
//   dout    : re-shaped pass-through line for chaining
//
// Parameter:
//   N_PIX   : maximum pixels per frame (pix counters are 9 bits wide)
//
// Build option:
//   WS2812_RX_FWD_EN : when defined, the first pixel of each frame is
//                      consumed and later bits are re-emitted on dout with
//                      T0H/T1H highs, like a real WS2812. When undefined,
//                      dout is tied 0 and no forwarding logic exists.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int N_PIX = 256
) (
    input  logic         clk_50m,
    input  logic         rst_n,
    input  logic         din,
    ws2812_rx_if.master  pix,
    output logic         dout
);

    localparam logic [CNT_W-1:0]     RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]     MIN_W      = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]     MAX_W      = CNT_W'(MAX_HIGH);
    localparam logic [PIX_CNT_W-1:0] PIX_LIMIT  = PIX_CNT_W'(N_PIX);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(PIX_W - 1);

    logic level;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .din     (din),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    rx_state_t            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0]     sh_q,      sh_d;
    logic                 ovf_q,     ovf_d;

    logic [PIX_W-1:0]     data_q,    data_d;
    logic [PIX_CNT_W-1:0] idx_q,     idx_d;
    logic [PIX_CNT_W-1:0] count_q,   count_d;
    logic                 valid_q,   valid_d;
    logic                 done_q,    done_d;
    logic                 err_q,     err_d;

    logic [CNT_W-1:0]     cnt_inc;
    logic                 new_bit;

    // cnt saturates; in HIGH, cnt_inc is the width of the pulse including
    // the current cycle, so a fall after W high cycles measures exactly W.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign new_bit = decode_bit(cnt_inc);

    // State and datapath registers; all outputs are registered so the
    // pixel strobe lands the cycle after the deciding fall.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SYNC;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
            sh_q      <= '0;
            ovf_q     <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            sh_q      <= sh_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and output decode. SYNC only looks for a clean reset gap
    // and never decodes, so joining a stream mid-frame yields no pixels.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        pix_cnt_d = pix_cnt_q;
        sh_d      = sh_q;
        ovf_d     = ovf_q;
        data_d    = data_q;
        idx_d     = idx_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            SYNC: begin
                if (level || rise) begin
                    cnt_d = '0;
                end else if (cnt_q == RESET_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            IDLE: begin
                if (rise) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = HIGH;
                end
            end

            HIGH: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= MAX_W) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SYNC;
                end else if (fall) begin
                    if (cnt_inc < MIN_W) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = SYNC;
                    end else begin
                        sh_d    = {sh_q[PIX_W-2:0], new_bit};
                        cnt_d   = '0;
                        state_d = LOW;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            // Beyond N_PIX the pixel is dropped and err is
                            // raised only once; decoding carries on to the gap.
                            if (pix_cnt_q == PIX_LIMIT) begin
                                if (!ovf_q) begin
                                    err_d = 1'b1;
                                    ovf_d = 1'b1;
                                end
                            end else begin
                                valid_d   = 1'b1;
                                data_d    = {sh_q[PIX_W-2:0], new_bit};
                                idx_d     = pix_cnt_q;
                                pix_cnt_d = pix_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end

            LOW: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else if (cnt_q == RESET_LAST) begin
                    // A partial pixel at the gap is discarded and flagged.
                    done_d  = 1'b1;
                    count_d = pix_cnt_q;
                    err_d   = (bit_cnt_q != '0);
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = SYNC;
            end
        endcase
    end

    assign pix.pix_data   = data_q;
    assign pix.pix_valid  = valid_q;
    assign pix.pix_idx    = idx_q;
    assign pix.frame_done = done_q;
    assign pix.pix_count  = count_q;
    assign pix.err        = err_q;

`ifdef WS2812_RX_FWD_EN
    logic                 fwd_on_q;
    logic                 dout_q;
    logic [FWD_CNT_W-1:0] fwd_cnt_q;

    // Forwarding is armed once the first 24 bits of a frame have been
    // consumed, and disarmed whenever the decoder is idle or resyncing.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            fwd_on_q <= 1'b0;
        end else if (state_q == SYNC || state_q == IDLE) begin
            fwd_on_q <= 1'b0;
        end else if (state_q == HIGH && state_d == LOW && bit_cnt_q == LAST_BIT) begin
            fwd_on_q <= 1'b1;
        end
    end

    // Re-shaped output: rise with the input, then sample the input at T0H
    // like a real pixel; if it is already low emit a 0, else hold to T1H.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            dout_q    <= 1'b0;
            fwd_cnt_q <= '0;
        end else if (state_q == SYNC || state_d == SYNC) begin
            dout_q    <= 1'b0;
            fwd_cnt_q <= '0;
        end else if (rise && fwd_on_q && state_q == LOW) begin
            dout_q    <= 1'b1;
            fwd_cnt_q <= FWD_CNT_W'(1);
        end else if (dout_q) begin
            if ((fwd_cnt_q == FWD_CNT_W'(T0H) && !level) ||
                fwd_cnt_q == FWD_CNT_W'(T1H)) begin
                dout_q    <= 1'b0;
                fwd_cnt_q <= '0;
            end else begin
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
            end
        end
    end

    assign dout = dout_q;
`else
    assign dout = 1'b0;
`endif

endmodule
